// File: rtl/fft_dac.sv
// Serial writer for the AD5683 DAC: frames {CMD, code, 4'b0} as 24 bits MSB first,
// with SCLK idling high and data changing only on SCLK rising edges.
module fft_dac #(
    parameter int         SCL_HALF = 2,
    parameter logic [3:0] CMD      = 4'b0011
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iEN,
    input  logic [15:0] iDATA,
    output logic        oDAC_DATA,
    output logic        oDAC_CS,
    output logic        oDAC_CLK
);
    localparam int CW = (SCL_HALF > 1) ? $clog2(SCL_HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(SCL_HALF - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_H, SHIFT_L, END} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    bit_cnt, bit_nxt;
    logic [23:0]   sr, sr_nxt;
    logic          cs, cs_nxt, sclk, sclk_nxt, sdo, sdo_nxt;
    logic [23:0]   frame;
    logic          half_done;

    assign frame     = {CMD, iDATA, 4'b0000};
    assign half_done = (cnt == HALF_LAST);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            sdo     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            sr      <= sr_nxt;
            cs      <= cs_nxt;
            sclk    <= sclk_nxt;
            sdo     <= sdo_nxt;
        end
    end

    // sr holds the bits still to be sent; the bit on the wire lives in sdo.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        sr_nxt    = sr;
        cs_nxt    = cs;
        sclk_nxt  = sclk;
        sdo_nxt   = sdo;
        case (state)
            IDLE: begin
                if (iEN) begin
                    sr_nxt    = {frame[22:0], 1'b0};
                    sdo_nxt   = frame[23];
                    cs_nxt    = 1'b0;
                    sclk_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = SHIFT_H;
                end
            end
            SHIFT_H: begin
                if (half_done) begin
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b0;
                    state_nxt = SHIFT_L;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT_L: begin
                if (half_done) begin
                    cnt_nxt  = '0;
                    sclk_nxt = 1'b1;
                    if (bit_cnt == 5'd23) begin
                        state_nxt = END;
                    end else begin
                        bit_nxt   = bit_cnt + 5'd1;
                        sdo_nxt   = sr[23];
                        sr_nxt    = {sr[22:0], 1'b0};
                        state_nxt = SHIFT_H;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            END: begin
                if (half_done) begin
                    cnt_nxt   = '0;
                    cs_nxt    = 1'b1;
                    sdo_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oDAC_DATA = sdo;
    assign oDAC_CS   = cs;
    assign oDAC_CLK  = sclk;
endmodule

// File: tb/tb_fft_dac.sv
// Bench for fft_dac: a bus monitor decodes each CS-low window into a captured word,
// falling-edge count, CS-low length and preceding CS-high gap; results are compared to expected frames.
module tb_fft_dac;
    localparam int H = 2;

    logic        iCLK = 1'b0;
    logic        iRESET, iEN, iEN1;
    logic [15:0] iDATA, iDATA1;
    logic        d0, cs0, ck0, d1, cs1, ck1;

    always #5 iCLK = ~iCLK;

    fft_dac #(.SCL_HALF(H)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iDATA(iDATA),
        .oDAC_DATA(d0), .oDAC_CS(cs0), .oDAC_CLK(ck0)
    );
    fft_dac #(.SCL_HALF(1)) dut1 (
        .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN1), .iDATA(iDATA1),
        .oDAC_DATA(d1), .oDAC_CS(cs1), .oDAC_CLK(ck1)
    );

    typedef struct {
        logic [23:0] word;
        int          nfall;
        int          cslen;
        int          gap;
    } frame_t;

    frame_t      q0[$], q1[$];
    logic [23:0] sh[2];
    int          nf[2], cl[2], gp[2], g0[2];
    logic        pck[2] = '{1'b1, 1'b1};
    logic        pcs[2] = '{1'b1, 1'b1};
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decodes the SPI-like bus as the DAC sees it: one bit per SCLK falling edge while CS is low.
    task automatic mon(input int i, input logic cs, input logic ck, input logic d,
                       output logic done, output frame_t f);
        done = 1'b0;
        f    = '{word: 24'h0, nfall: 0, cslen: 0, gap: 0};
        if (!cs) begin
            if (pcs[i]) begin
                sh[i] = '0; nf[i] = 0; cl[i] = 0; g0[i] = gp[i];
            end
            cl[i]++;
            if (pck[i] && !ck) begin
                sh[i] = {sh[i][22:0], d};
                nf[i]++;
            end
        end else begin
            if (!pcs[i]) begin
                done = 1'b1;
                f = '{word: sh[i], nfall: nf[i], cslen: cl[i], gap: g0[i]};
                gp[i] = 0;
            end
            gp[i]++;
        end
        pck[i] = ck;
        pcs[i] = cs;
    endtask

    always @(negedge iCLK) begin
        logic   dn;
        frame_t f;
        mon(0, cs0, ck0, d0, dn, f);
        if (dn) q0.push_back(f);
        mon(1, cs1, ck1, d1, dn, f);
        if (dn) q1.push_back(f);
    end

    task automatic expect_frame(input string tag, input logic [15:0] v, input int h, input frame_t f);
        chk({tag, ".word"},  f.word,  {4'b0011, v, 4'b0000});
        chk({tag, ".nfall"}, f.nfall, 24);
        chk({tag, ".cslen"}, f.cslen, 49 * h);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (q0.size() < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk({tag, ".timeout"}, q0.size() >= n, 1);
    endtask

    task automatic run_one(input string tag, input logic [15:0] v);
        frame_t f;
        @(negedge iCLK); iEN = 1'b1; iDATA = v;
        @(negedge iCLK); iEN = 1'b0;
        chk({tag, ".cs_fall"}, cs0, 1'b0);
        wait_frames(tag, 1, 49 * H + 20);
        if (q0.size() > 0) begin
            f = q0.pop_front();
            expect_frame(tag, v, H, f);
        end
    endtask

    task automatic run_one1(input string tag, input logic [15:0] v);
        frame_t f;
        int     k = 0;
        @(negedge iCLK); iEN1 = 1'b1; iDATA1 = v;
        @(negedge iCLK); iEN1 = 1'b0;
        chk({tag, ".cs_fall"}, cs1, 1'b0);
        while (q1.size() < 1 && k < 80) begin
            @(negedge iCLK);
            k++;
        end
        chk({tag, ".timeout"}, q1.size() >= 1, 1);
        if (q1.size() > 0) begin
            f = q1.pop_front();
            expect_frame(tag, v, 1, f);
        end
    endtask

    initial begin
        logic [15:0] v, x;
        frame_t      f;
        int          k, n;

        // iEN held during reset must not start anything
        iRESET = 1'b1; iEN = 1'b1; iDATA = 16'h5A5A; iEN1 = 1'b0; iDATA1 = 16'h0;
        repeat (3) @(negedge iCLK);
        chk("rst.cs", cs0, 1'b1);
        chk("rst.clk", ck0, 1'b1);
        chk("rst.data", d0, 1'b0);
        iRESET = 1'b0; iEN = 1'b0;
        repeat (5) @(negedge iCLK);
        chk("rst_en_ignored", cs0, 1'b1);
        q0.delete(); q1.delete();

        run_one("f1234", 16'h1234);
        repeat (10) @(negedge iCLK);
        run_one("fAAAA", 16'hAAAA);
        repeat (10) @(negedge iCLK);
        run_one("fFFFF", 16'hFFFF);
        run_one("f0000", 16'h0000);

        for (int i = 0; i < 10; i++) begin
            run_one("rand", 16'($urandom));
            repeat (100) @(negedge iCLK);
        end

        // a second pulse and iDATA churn mid-frame must not disturb or queue anything
        x = 16'($urandom);
        @(negedge iCLK); iEN = 1'b1; iDATA = x;
        @(negedge iCLK); iEN = 1'b0;
        repeat (30) @(negedge iCLK);
        iEN = 1'b1; iDATA = ~x;
        @(negedge iCLK); iEN = 1'b0; iDATA = 16'($urandom);
        wait_frames("mid", 1, 200);
        repeat (150) @(negedge iCLK);
        chk("mid.count", q0.size(), 1);
        if (q0.size() > 0) begin
            f = q0.pop_front();
            expect_frame("mid", x, H, f);
        end
        q0.delete();

        // iEN held high: back-to-back frames with a single-cycle CS-high gap
        v = 16'($urandom);
        @(negedge iCLK); iEN = 1'b1; iDATA = v;
        wait_frames("b2b", 3, 400);
        @(negedge iCLK); iEN = 1'b0;
        repeat (150) @(negedge iCLK);
        n = q0.size();
        chk("b2b.count", n >= 3, 1);
        for (int i = 0; i < n; i++) begin
            f = q0.pop_front();
            expect_frame("b2b", v, H, f);
            if (i > 0) chk("b2b.gap", f.gap, 1);
        end

        // reset part-way through a frame aborts it for good
        v = 16'($urandom);
        @(negedge iCLK); iEN = 1'b1; iDATA = v;
        @(negedge iCLK); iEN = 1'b0;
        k = 0;
        while (nf[0] < 10 && k < 100) begin
            @(negedge iCLK);
            k++;
        end
        chk("abort.reach_bit10", nf[0] >= 10, 1);
        iRESET = 1'b1; iEN = 1'b1;
        @(negedge iCLK);
        chk("abort.cs", cs0, 1'b1);
        chk("abort.clk", ck0, 1'b1);
        chk("abort.data", d0, 1'b0);
        iRESET = 1'b0; iEN = 1'b0;
        repeat (5) @(negedge iCLK);
        q0.delete();
        repeat (120) @(negedge iCLK);
        chk("abort.no_resume", q0.size(), 0);
        chk("abort.idle_cs", cs0, 1'b1);
        run_one("after_abort", 16'($urandom));

        // narrowest serial clock build
        run_one1("h1_0001", 16'h0001);
        repeat (5) @(negedge iCLK);
        for (int i = 0; i < 3; i++) begin
            run_one1("h1_rand", 16'($urandom));
            repeat (5) @(negedge iCLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
